linebuf_wr_sched: RTL and testbench

Single-clock write-side scheduler for the iter8 scanline double-buffer. On each line request it hands pixel x-coordinates of one scanline to N Mandelbrot iteration engines, arbitrates their results onto the single buffer write port, and ping-pongs the write bank. It reports each completed bank to the display side. It sits in the compute clock domain, between the iteration engines and the line buffer's write port.

---
 rtl/linebuf_wr_sched.sv | 197 +++++++++++++++++++
 tb/tb_linebuf_wr_sched.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/linebuf_wr_sched.sv
// linebuf_wr_sched: issues one scanline of pixel jobs to the iteration
// engines, funnels their results onto the line buffer write port and
// ping-pongs the write bank between lines.
//
// state    | meaning
// IDLE     | no line in progress, waiting for line_req
// DISPATCH | offering x coordinates to engines and collecting results
// DRAIN    | every x issued, collecting the outstanding results
module linebuf_wr_sched #(
  parameter int N_ENG = 4,
  parameter int MAX_W = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                line_req,
  input  logic [9:0]          line_y,
  input  logic [10:0]         cfg_width,
  output logic [N_ENG-1:0]    job_valid,
  output logic [9:0]          job_x,
  output logic [9:0]          job_y,
  input  logic [N_ENG-1:0]    job_ready,
  input  logic [N_ENG-1:0]    res_valid,
  input  logic [10*N_ENG-1:0] res_x,
  input  logic [8*N_ENG-1:0]  res_iter,
  output logic [N_ENG-1:0]    res_ready,
  output logic                lb_we,
  output logic                lb_bank,
  output logic [9:0]          lb_addr,
  output logic [7:0]          lb_data,
  output logic                busy,
  output logic                line_done,
  output logic                done_bank,
  output logic                overrun
);
  localparam int PW = (N_ENG > 1) ? $clog2(N_ENG) : 1;
  localparam logic [10:0] MAX_W_L = 11'(MAX_W);

  typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN} state_t;
  state_t state, state_nxt;

  logic [10:0]      width, ix, wc, width_in;
  logic             wr_bank;
  logic [PW-1:0]    iss_ptr, res_ptr;
  logic [N_ENG-1:0] offer, res_gnt, job_acc;
  logic             res_hs, line_fin, start, zero_line, ovr;
  logic [9:0]       sel_x;
  logic [7:0]       sel_iter;

  // One-hot grant to the first requester at or after ptr, wrapping around.
  function automatic logic [N_ENG-1:0] rr_pick(input logic [N_ENG-1:0] req,
                                               input logic [PW-1:0] ptr);
    logic [N_ENG-1:0] gnt;
    logic [PW-1:0]    idx;
    gnt = '0;
    for (int k = N_ENG - 1; k >= 0; k--) begin
      idx = PW'((int'(ptr) + k) % N_ENG);
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
      end
    end
    return gnt;
  endfunction

  // Pointer value one past the granted engine.
  function automatic logic [PW-1:0] ptr_after(input logic [N_ENG-1:0] oh);
    logic [PW-1:0] p;
    p = '0;
    for (int i = 0; i < N_ENG; i++) begin
      if (oh[i]) p = PW'((i + 1) % N_ENG);
    end
    return p;
  endfunction

  assign width_in = (cfg_width > MAX_W_L) ? MAX_W_L : cfg_width;
  assign res_gnt  = rr_pick(res_valid, res_ptr);
  assign job_acc  = job_valid & job_ready;
  assign res_hs   = |res_ready;
  // Completion is decided on the final handshake so line_done lines up with its write.
  assign line_fin = res_hs && ((wc + 11'd1) == width);
  assign busy     = (state != IDLE);

  // Select the granted engine's result fields.
  always_comb begin
    sel_x    = '0;
    sel_iter = '0;
    for (int i = 0; i < N_ENG; i++) begin
      if (res_ready[i]) begin
        sel_x    = sel_x | res_x[10*i +: 10];
        sel_iter = sel_iter | res_iter[8*i +: 8];
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state, job offer selection and combinational result grant.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    zero_line = 1'b0;
    ovr       = 1'b0;
    offer     = '0;
    res_ready = '0;
    case (state)
      IDLE: begin
        if (line_req) begin
          if (width_in == 11'd0) begin
            zero_line = 1'b1;
          end else begin
            start     = 1'b1;
            state_nxt = DISPATCH;
          end
        end
      end
      DISPATCH: begin
        ovr       = line_req;
        res_ready = res_gnt;
        if (line_fin) begin
          state_nxt = IDLE;
        end else if ((ix == width) && !(|job_valid)) begin
          state_nxt = DRAIN;
        end
        if (!(|job_valid) && (ix < width)) offer = rr_pick(job_ready, iss_ptr);
      end
      DRAIN: begin
        ovr       = line_req;
        res_ready = res_gnt;
        if (line_fin) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Line latches, job offer, write port, counters and bank bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      width     <= '0;
      ix        <= '0;
      wc        <= '0;
      wr_bank   <= 1'b0;
      iss_ptr   <= '0;
      res_ptr   <= '0;
      job_valid <= '0;
      job_x     <= '0;
      job_y     <= '0;
      lb_we     <= 1'b0;
      lb_bank   <= 1'b0;
      lb_addr   <= '0;
      lb_data   <= '0;
      line_done <= 1'b0;
      done_bank <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      lb_we     <= 1'b0;
      line_done <= 1'b0;
      overrun   <= ovr;
      if (start || zero_line) begin
        job_y <= line_y;
        width <= width_in;
        ix    <= '0;
        wc    <= '0;
      end
      if (zero_line) begin
        line_done <= 1'b1;
        done_bank <= wr_bank;
        wr_bank   <= ~wr_bank;
      end
      if (|offer) begin
        job_valid <= offer;
        job_x     <= ix[9:0];
        iss_ptr   <= ptr_after(offer);
      end else if (|job_acc) begin
        job_valid <= '0;
        ix        <= ix + 11'd1;
      end
      if (res_hs) begin
        lb_we   <= 1'b1;
        lb_addr <= sel_x;
        lb_data <= sel_iter;
        lb_bank <= wr_bank;
        wc      <= wc + 11'd1;
        res_ptr <= ptr_after(res_ready);
      end
      if (line_fin) begin
        line_done <= 1'b1;
        done_bank <= wr_bank;
        wr_bank   <= ~wr_bank;
      end
    end
  end

endmodule

// File: tb/tb_linebuf_wr_sched.sv
// Bench for linebuf_wr_sched: behavioural engine models, a line-level
// scoreboard, a table of whole-line vectors and hand-written corner sequences.
module tb_linebuf_wr_sched;
  localparam int N  = 4;
  localparam int MW = 1024;

  logic            clk = 1'b0;
  logic            rst;
  logic            line_req;
  logic [9:0]      line_y;
  logic [10:0]     cfg_width;
  logic [N-1:0]    job_valid, job_ready, res_valid, res_ready;
  logic [9:0]      job_x, job_y;
  logic [10*N-1:0] res_x;
  logic [8*N-1:0]  res_iter;
  logic            lb_we, lb_bank, busy, line_done, done_bank, overrun;
  logic [9:0]      lb_addr;
  logic [7:0]      lb_data;

  always #5 clk = ~clk;

  linebuf_wr_sched #(.N_ENG(N), .MAX_W(MW)) dut (
    .clk(clk), .rst(rst), .line_req(line_req), .line_y(line_y), .cfg_width(cfg_width),
    .job_valid(job_valid), .job_x(job_x), .job_y(job_y), .job_ready(job_ready),
    .res_valid(res_valid), .res_x(res_x), .res_iter(res_iter), .res_ready(res_ready),
    .lb_we(lb_we), .lb_bank(lb_bank), .lb_addr(lb_addr), .lb_data(lb_data),
    .busy(busy), .line_done(line_done), .done_bank(done_bank), .overrun(overrun)
  );

  int checks = 0;
  int failures = 0;

  // line-level reference state
  bit m_busy;
  int m_width, m_y, issued, written;
  bit cur_bank;
  bit written_map[MW];
  bit e_we, e_wbank, e_done, e_dbank, e_ovr, done_pred;
  int e_addr, e_data;
  // engine models
  bit eb[N], ev[N];
  int ex[N], ey[N], ecnt[N];
  int lat_mode, ready_pct;
  // observed DUT activity
  int obs_writes, obs_done, obs_dbank, obs_ovr;
  bit done_q[$];

  typedef struct {
    int y;
    int cfg;
    int mode;
    int rpct;
    int exp_w;
    int exp_bank;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int f_iter(input int x, input int y);
    return (x ^ y) & 255;
  endfunction

  function automatic int first1(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic clear_model();
    m_busy = 0; m_width = 0; issued = 0; written = 0; cur_bank = 0;
    e_we = 0; e_done = 0; e_ovr = 0; done_pred = 0;
    for (int i = 0; i < N; i++) begin eb[i] = 0; ev[i] = 0; ex[i] = 0; ey[i] = 0; ecnt[i] = 0; end
    line_req = 0; job_ready = '0; res_valid = '0; res_x = '0; res_iter = '0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_job_valid"}, job_valid, 0);
    chk({tag, "_res_ready"}, res_ready, 0);
    chk({tag, "_lb_we"}, lb_we, 0);
    chk({tag, "_lb_bank"}, lb_bank, 0);
    chk({tag, "_lb_addr"}, lb_addr, 0);
    chk({tag, "_lb_data"}, lb_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_line_done"}, line_done, 0);
    chk({tag, "_done_bank"}, done_bank, 0);
    chk({tag, "_overrun"}, overrun, 0);
    chk({tag, "_job_x"}, job_x, 0);
    chk({tag, "_job_y"}, job_y, 0);
  endtask

  task automatic do_reset();
    clear_model();
    rst = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;
  endtask

  // One clock: check registered outputs, predict this edge's handshakes,
  // then advance the engine models and drive their new outputs.
  task automatic cycle();
    logic [N-1:0] acc, gnt;
    bit was_busy;
    int i;
    @(negedge clk);
    chk("lb_we", lb_we, e_we);
    if (lb_we) obs_writes++;
    if (e_we && lb_we) begin
      chk("lb_addr", lb_addr, e_addr);
      chk("lb_data", lb_data, e_data);
      chk("lb_bank", lb_bank, e_wbank);
    end
    chk("line_done", line_done, e_done);
    if (line_done) begin obs_done++; obs_dbank = done_bank; done_q.push_back(done_bank); end
    if (e_done && line_done) chk("done_bank", done_bank, e_dbank);
    chk("overrun", overrun, e_ovr);
    if (overrun) obs_ovr++;
    chk("busy", busy, m_busy);

    acc = job_valid & job_ready;
    gnt = res_valid & res_ready;
    was_busy = m_busy;
    e_we = 0; e_done = 0; e_ovr = 0; done_pred = 0;
    chk("job_onehot", ($countones(job_valid) <= 1) ? 1 : 0, 1);
    chk("res_ready_subset", res_ready & ~res_valid, 0);
    if (was_busy) begin
      chk("res_grant", $countones(res_ready), (res_valid != '0) ? 1 : 0);
    end else begin
      chk("idle_res_ready", res_ready, 0);
      chk("idle_job_valid", job_valid, 0);
    end

    if (acc != '0) begin
      i = first1(acc);
      chk("job_x", job_x, issued);
      chk("job_y", job_y, m_y);
      chk("issue_bound", (issued < m_width) ? 1 : 0, 1);
      eb[i] = 1; ev[i] = 0; ex[i] = int'(job_x); ey[i] = int'(job_y);
      ecnt[i] = (lat_mode == 0) ? 5 : int'($urandom_range(40, 1));
      issued++;
    end
    if (gnt != '0) begin
      i = first1(gnt);
      chk("dup_write", written_map[ex[i]], 0);
      written_map[ex[i]] = 1;
      e_we = 1; e_addr = ex[i]; e_data = f_iter(ex[i], ey[i]); e_wbank = cur_bank;
      eb[i] = 0; ev[i] = 0;
      written++;
      if (written == m_width) begin
        chk("issued_all", issued, m_width);
        e_done = 1; e_dbank = cur_bank; cur_bank = ~cur_bank; m_busy = 0; done_pred = 1;
      end
    end
    if (line_req) begin
      if (was_busy) begin
        e_ovr = 1;
      end else begin
        m_y = int'(line_y);
        m_width = (int'(cfg_width) > MW) ? MW : int'(cfg_width);
        issued = 0; written = 0;
        for (int k = 0; k < MW; k++) written_map[k] = 0;
        if (m_width == 0) begin
          e_done = 1; e_dbank = cur_bank; cur_bank = ~cur_bank; done_pred = 1;
        end else begin
          m_busy = 1;
        end
      end
    end

    @(posedge clk); #1;
    line_req = 0;
    for (int k = 0; k < N; k++) begin
      if (eb[k] && !ev[k]) begin
        if (ecnt[k] > 0) ecnt[k]--;
        if (ecnt[k] == 0) ev[k] = 1;
      end
      res_valid[k] = ev[k];
      res_x[10*k +: 10] = 10'(ex[k]);
      res_iter[8*k +: 8] = 8'(f_iter(ex[k], ey[k]));
      job_ready[k] = !eb[k] && (int'($urandom_range(99, 0)) < ready_pct);
    end
  endtask

  task automatic run_line(input int y, input int cfg, input int mode, input int rpct);
    int n;
    lat_mode = mode; ready_pct = rpct;
    obs_writes = 0; obs_done = 0; obs_ovr = 0;
    line_req = 1; line_y = 10'(y); cfg_width = 11'(cfg);
    cycle();
    n = 0;
    while ((m_busy || e_we || e_done || e_ovr) && n < 20000) begin
      cycle();
      n++;
    end
    if (n >= 20000) begin
      failures++;
      $display("FAIL line_timeout: got %0d writes expected %0d", written, m_width);
    end
  endtask

  initial begin
    int n, w, cfg, started;
    rst = 1; line_y = '0; cfg_width = '0;
    clear_model();
    vecs[0] = '{0,    8,    0, 100, 8,    0};
    vecs[1] = '{3,    8,    0, 100, 8,    1};
    vecs[2] = '{9,    0,    1, 100, 0,    0};
    vecs[3] = '{100,  1024, 1, 90,  1024, 1};
    vecs[4] = '{101,  1500, 1, 70,  1024, 0};
    vecs[5] = '{1023, 1,    1, 50,  1,    1};
    vecs[6] = '{7,    3,    1, 100, 3,    0};

    do_reset();

    for (int t = 0; t < 7; t++) begin
      run_line(vecs[t].y, vecs[t].cfg, vecs[t].mode, vecs[t].rpct);
      chk("tbl_writes", obs_writes, vecs[t].exp_w);
      chk("tbl_done_count", obs_done, 1);
      chk("tbl_done_bank", obs_dbank, vecs[t].exp_bank);
      chk("tbl_overrun", obs_ovr, 0);
    end

    // overrun mid-line: dropped request must not disturb the running line
    lat_mode = 1; ready_pct = 80;
    obs_writes = 0; obs_done = 0; obs_ovr = 0;
    line_req = 1; line_y = 10'd50; cfg_width = 11'd40;
    cycle();
    for (int k = 0; k < 20; k++) cycle();
    line_req = 1; line_y = 10'd999; cfg_width = 11'd2;
    n = 0;
    do begin cycle(); n++; end while ((m_busy || e_we || e_done || e_ovr) && n < 5000);
    chk("ovr_pulses", obs_ovr, 1);
    chk("ovr_writes", obs_writes, 40);
    chk("ovr_done", obs_done, 1);

    // randomized widths
    for (int r = 0; r < 3; r++) begin
      cfg = int'($urandom_range(1100, 0));
      w = (cfg > MW) ? MW : cfg;
      run_line(int'($urandom_range(1023, 0)), cfg, 1, int'($urandom_range(100, 30)));
      chk("rnd_writes", obs_writes, w);
      chk("rnd_done", obs_done, 1);
    end

    // reset after three writes of a line
    lat_mode = 0; ready_pct = 100;
    obs_writes = 0;
    line_req = 1; line_y = 10'd77; cfg_width = 11'd16;
    n = 0;
    do begin cycle(); n++; end while (obs_writes < 3 && n < 500);
    chk("pre_reset_writes", obs_writes, 3);
    clear_model();
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    check_zero("midreset");
    @(posedge clk); #1;

    // fairness: every engine always valid, no jobs accepted
    job_ready = '0; res_valid = '1;
    for (int k = 0; k < N; k++) begin
      res_x[10*k +: 10] = 10'(k);
      res_iter[8*k +: 8] = 8'(k);
    end
    line_req = 1; line_y = 10'd0; cfg_width = 11'd8;
    @(posedge clk); #1;
    line_req = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("rr_grant", res_ready, 1 << (k % N));
      @(posedge clk); #1;
    end
    res_valid = '0;
    @(negedge clk);
    chk("rr_line_done", line_done, 1);
    chk("rr_done_bank", done_bank, 0);
    chk("rr_busy", busy, 0);
    @(posedge clk); #1;

    // back-to-back lines: next request in the line_done cycle
    do_reset();
    lat_mode = 0; ready_pct = 100;
    obs_ovr = 0; done_q.delete();
    line_req = 1; line_y = 10'd1; cfg_width = 11'd4;
    started = 1; n = 0;
    do begin
      cycle();
      n++;
      if (done_pred && started < 3) begin
        line_req = 1; line_y = 10'(started + 1); cfg_width = 11'd4;
        started++;
      end
    end while ((m_busy || e_we || e_done || e_ovr || line_req) && n < 2000);
    chk("b2b_lines", done_q.size(), 3);
    chk("b2b_bank0", (done_q.size() > 0) ? int'(done_q[0]) : 2, 0);
    chk("b2b_bank1", (done_q.size() > 1) ? int'(done_q[1]) : 2, 1);
    chk("b2b_bank2", (done_q.size() > 2) ? int'(done_q[2]) : 2, 0);
    chk("b2b_overrun", obs_ovr, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
